// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue sequencer: op codes, control-word
// bit positions and the sequencer state encoding.
package fpu_pkg;

  localparam logic [3:0] OP_FSUB     = 4'd0;
  localparam logic [3:0] OP_FADD     = 4'd1;
  localparam logic [3:0] OP_FMUL     = 4'd2;
  localparam logic [3:0] OP_FDIV     = 4'd3;
  localparam logic [3:0] OP_FSGNJ    = 4'd4;
  localparam logic [3:0] OP_FMINMAX  = 4'd5;
  localparam logic [3:0] OP_FSQRT    = 4'd6;
  localparam logic [3:0] OP_FCMP     = 4'd7;
  localparam logic [3:0] OP_FCVT_W_S = 4'd8;
  localparam logic [3:0] OP_FCVT_S_W = 4'd9;
  localparam logic [3:0] OP_FMADD    = 4'd10;
  localparam logic [3:0] OP_FMSUB    = 4'd11;
  localparam logic [3:0] OP_FNMSUB   = 4'd12;
  localparam logic [3:0] OP_FNMADD   = 4'd13;

  localparam int CW_FPUOP    = 19;
  localparam int CW_FPU_SEL  = 18;
  localparam int CW_FREG_WR  = 15;
  localparam int CW_ALUOP_HI = 10;
  localparam int CW_ALUOP_LO = 8;
  localparam int CW_REG_WR   = 4;

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

endpackage

// File: rtl/fpu_lat_lut.sv
// Combinational op-code to latency table; emits LAT-1, the value the
// sequencer loads into its down-counter on accept.
module fpu_lat_lut
  import fpu_pkg::*;
#(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_DIV  = 16,
  parameter int LAT_SQRT = 16,
  parameter int LAT_MISC = 1,
  parameter int LAT_CVT  = 2,
  parameter int LAT_FMA  = 6
) (
  input  logic [3:0]       op_i,
  output logic [CNT_W-1:0] lat_m1_o
);

  function automatic int lat_of(input logic [3:0] op);
    case (op)
      OP_FSUB, OP_FADD:                        return LAT_ADD;
      OP_FMUL:                                 return LAT_MUL;
      OP_FDIV:                                 return LAT_DIV;
      OP_FSQRT:                                return LAT_SQRT;
      OP_FCVT_W_S, OP_FCVT_S_W:                return LAT_CVT;
      OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: return LAT_FMA;
      default:                                 return LAT_MISC;
    endcase
  endfunction

  logic [CNT_W-1:0] lut_m1 [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_lut
    localparam int LAT = lat_of(4'(gi));
    // A 5-bit counter holding LAT-1 only covers 1..32.
    if (LAT < 1 || LAT > 32) begin : g_bad
      $error("fpu_lat_lut: latency %0d for op %0d outside 1..32", LAT, gi);
    end
    assign lut_m1[gi] = CNT_W'(LAT - 1);
  end

  assign lat_m1_o = lut_m1[op_i];

endmodule

// File: rtl/fpu_issue_seq.sv
// Execute-stage sequencer: issues one FPU op at a time, times it with a
// per-op latency counter, stalls the front end and requests writeback.
module fpu_issue_seq
  import fpu_pkg::*;
#(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_DIV  = 16,
  parameter int LAT_SQRT = 16,
  parameter int LAT_MISC = 1,
  parameter int LAT_CVT  = 2,
  parameter int LAT_FMA  = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  input  logic [19:0] ctrl_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  input  logic        wb_ready_i,
  output logic        stall_o,
  output logic        fpu_start_o,
  output logic [3:0]  fpu_op_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_float_o,
  output logic        busy_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic             float_q, float_d;
  logic             start_q, start_d;

  logic [3:0]       op_in;
  logic [CNT_W-1:0] lat_m1;
  logic             accept;
  logic             unused_ctrl;

  assign op_in  = {ctrl_i[CW_FPUOP], ctrl_i[CW_ALUOP_HI:CW_ALUOP_LO]};
  assign accept = (state_q == IDLE) && in_valid_i && ctrl_i[CW_FPU_SEL] && !flush_i;
  assign unused_ctrl = ^{ctrl_i[17:16], ctrl_i[14:11], ctrl_i[7:0]};

  fpu_lat_lut #(
    .LAT_ADD  (LAT_ADD),
    .LAT_MUL  (LAT_MUL),
    .LAT_DIV  (LAT_DIV),
    .LAT_SQRT (LAT_SQRT),
    .LAT_MISC (LAT_MISC),
    .LAT_CVT  (LAT_CVT),
    .LAT_FMA  (LAT_FMA)
  ) u_lat_lut (
    .op_i     (op_in),
    .lat_m1_o (lat_m1)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    float_d = float_q;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = op_in;
          rd_d    = rd_i;
          float_d = ctrl_i[CW_FREG_WR];
          cnt_d   = lat_m1;
          start_d = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (flush_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = WB;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WB: begin
        if (flush_i || wb_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      float_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      float_q <= float_d;
      start_q <= start_d;
    end
  end

  // Stall is derived from registered state only, so the decoder never sees
  // a combinational loop through in_valid_i.
  assign busy_o      = (state_q != IDLE);
  assign stall_o     = busy_o;
  assign fpu_start_o = start_q;
  assign fpu_op_o    = (state_q == EXEC) ? op_q : 4'd0;
  assign wb_valid_o  = (state_q == WB) && !flush_i;
  assign wb_rd_o     = (state_q == WB) ? rd_q : 5'd0;
  assign wb_float_o  = (state_q == WB) && float_q;

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Directed bench for fpu_issue_seq: latency, writeback handshake, stall,
// flush, asynchronous reset and non-FPU pass-through.
module tb_fpu_issue_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i;
  logic [19:0] ctrl_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        wb_ready_i;
  logic        stall_o;
  logic        fpu_start_o;
  logic [3:0]  fpu_op_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic        wb_float_o;
  logic        busy_o;

  int n_err = 0;
  int n_chk = 0;

  fpu_issue_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .ctrl_i      (ctrl_i),
    .rd_i        (rd_i),
    .flush_i     (flush_i),
    .wb_ready_i  (wb_ready_i),
    .stall_o     (stall_o),
    .fpu_start_o (fpu_start_o),
    .fpu_op_o    (fpu_op_o),
    .wb_valid_o  (wb_valid_o),
    .wb_rd_o     (wb_rd_o),
    .wb_float_o  (wb_float_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {27'd0, stall_o, fpu_start_o, fpu_op_o, wb_valid_o, wb_rd_o, wb_float_o, busy_o}, 32'd0);
  endtask

  // Present an instruction for one edge; caller decides what stays on the bus.
  task automatic issue(input logic [19:0] ctrl, input logic [4:0] rd);
    in_valid_i = 1'b1;
    ctrl_i     = ctrl;
    rd_i       = rd;
    tick();
  endtask

  // Called in the first cycle after the accept edge. Measures edges from the
  // accept edge to the first wb_valid_o, holds the grant off for 'hold' WB
  // cycles, then grants and checks the return to IDLE.
  task automatic follow(input string tag, input logic [3:0] e_op, input int e_lat,
                        input logic e_flt, input logic [4:0] e_rd, input int hold);
    int k;
    int stall_cnt;
    int extra_start;
    int op_bad;
    int wb_drop;
    chk({tag, "_start"}, fpu_start_o, 1'b1);
    chk({tag, "_op"}, fpu_op_o, e_op);
    k = 0;
    stall_cnt = stall_o ? 1 : 0;
    extra_start = 0;
    op_bad = 0;
    wb_drop = 0;
    while (wb_valid_o !== 1'b1 && k < 40) begin
      tick();
      k++;
      if (fpu_start_o) extra_start++;
      if (stall_o) stall_cnt++;
      if (!wb_valid_o && fpu_op_o !== e_op) op_bad++;
    end
    chk({tag, "_latency"}, k, e_lat);
    chk({tag, "_wb_rd"}, wb_rd_o, e_rd);
    chk({tag, "_wb_float"}, wb_float_o, e_flt);
    for (int i = 0; i < hold; i++) begin
      tick();
      if (stall_o) stall_cnt++;
      if (fpu_start_o) extra_start++;
      if (wb_valid_o !== 1'b1 || wb_rd_o !== e_rd || wb_float_o !== e_flt) wb_drop++;
    end
    chk({tag, "_wb_steady"}, wb_drop, 0);
    chk({tag, "_op_steady"}, op_bad, 0);
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;
    chk({tag, "_idle_busy"}, busy_o, 1'b0);
    chk({tag, "_idle_wbv"}, wb_valid_o, 1'b0);
    chk({tag, "_one_start"}, extra_start, 0);
    chk({tag, "_stall_cycles"}, stall_cnt, e_lat + hold + 1);
    $display("txn %s op=%0d lat=%0d hold=%0d rd=%0d float=%0b", tag, e_op, k, hold, e_rd, e_flt);
  endtask

  initial begin
    int ns_busy;
    rst_n      = 1'b0;
    in_valid_i = 1'b0;
    ctrl_i     = '0;
    rd_i       = '0;
    flush_i    = 1'b0;
    wb_ready_i = 1'b0;
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // FADD: op 1, latency 3, float destination.
    issue(20'h78100, 5'd5);
    in_valid_i = 1'b0;
    follow("fadd", 4'd1, 3, 1'b1, 5'd5, 0);

    // FDIV with the grant withheld for 4 WB cycles.
    issue(20'h48300, 5'd12);
    in_valid_i = 1'b0;
    follow("fdiv", 4'd3, 16, 1'b1, 5'd12, 4);

    // FCVT.W.S: op 8, latency 2, integer destination.
    issue(20'hD0010, 5'd3);
    in_valid_i = 1'b0;
    follow("fcvt_w_s", 4'd8, 2, 1'b0, 5'd3, 0);

    // Single-cycle latency boundary: FCMP and undefined op 15.
    issue(20'h40710, 5'd1);
    in_valid_i = 1'b0;
    follow("fcmp", 4'd7, 1, 1'b0, 5'd1, 1);
    issue(20'hC8700, 5'd31);
    in_valid_i = 1'b0;
    follow("op15", 4'd15, 1, 1'b1, 5'd31, 0);

    // FMUL with an FADD waiting on the bus the whole time.
    issue(20'h48200, 5'd7);
    ctrl_i = 20'h78100;
    rd_i   = 5'd9;
    follow("fmul_b2b", 4'd2, 4, 1'b1, 5'd7, 0);
    chk("b2b_gap_start", fpu_start_o, 1'b0);
    tick();
    in_valid_i = 1'b0;
    follow("fadd_b2b", 4'd1, 3, 1'b1, 5'd9, 0);

    // Non-FPU instructions are never accepted.
    ns_busy = 0;
    in_valid_i = 1'b1;
    ctrl_i = 20'h00210;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (stall_o || busy_o || fpu_start_o) ns_busy++;
    end
    ctrl_i = 20'h10010;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (stall_o || busy_o || fpu_start_o) ns_busy++;
    end
    in_valid_i = 1'b0;
    chk("non_fpu_ignored", ns_busy, 0);
    $display("txn non_fpu busy_cycles=%0d", ns_busy);

    // Flush in the second EXEC cycle of an FMA.
    issue(20'hC8200, 5'd4);
    in_valid_i = 1'b0;
    chk("fma_start", fpu_start_o, 1'b1);
    tick();
    flush_i = 1'b1;
    #1;
    chk("fma_flush_wbv", wb_valid_o, 1'b0);
    tick();
    flush_i = 1'b0;
    chk("fma_flush_idle", busy_o, 1'b0);
    ns_busy = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (wb_valid_o || busy_o) ns_busy++;
    end
    chk("fma_no_wb", ns_busy, 0);
    $display("txn fma_flush");
    issue(20'h78100, 5'd6);
    in_valid_i = 1'b0;
    follow("fadd_after_flush", 4'd1, 3, 1'b1, 5'd6, 0);

    // Flush while waiting in WB drops wb_valid_o at once.
    issue(20'h78100, 5'd8);
    in_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("wb_wait_valid", wb_valid_o, 1'b1);
    flush_i = 1'b1;
    #1;
    chk("wb_flush_drop", wb_valid_o, 1'b0);
    tick();
    chk("wb_flush_idle", busy_o, 1'b0);
    $display("txn wb_flush");

    // Flush coincident with an accept blocks the accept.
    in_valid_i = 1'b1;
    ctrl_i = 20'h78100;
    tick();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    chk("flush_blocks_accept", busy_o, 1'b0);
    $display("txn flush_accept");

    // Asynchronous reset in the middle of an FDIV.
    issue(20'h48300, 5'd10);
    in_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    ns_busy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wb_valid_o || busy_o) ns_busy++;
    end
    chk("rst_no_wb", ns_busy, 0);
    $display("txn async_reset");
    issue(20'h78100, 5'd2);
    in_valid_i = 1'b0;
    follow("fadd_after_rst", 4'd1, 3, 1'b1, 5'd2, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
